// File: rtl/demux2_stream.sv
// 1-to-2 registered stream demultiplexer: each input beat is steered by Select into
// one of two independent FIFOs, so a stalled sink never blocks the other one.
module demux2_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     Select,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [WIDTH-1:0]         DataOutA,
    output logic                     ValidA,
    input  logic                     ReadyA,
    output logic [WIDTH-1:0]         DataOutB,
    output logic                     ValidB,
    input  logic                     ReadyB,
    output logic [$clog2(DEPTH):0]   CountA,
    output logic [$clog2(DEPTH):0]   CountB
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Index 0 is output A, index 1 is output B.
    logic [1:0]                  push;
    logic [1:0]                  pop;
    logic [1:0]                  valid;
    logic [1:0]                  not_full;
    logic [1:0]                  sink_ready;
    logic [1:0][WIDTH-1:0]       head;
    logic [1:0][CW-1:0]          count;
    logic                        accept;

    // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot.
    assign InReady    = !Reset && (Select ? not_full[1] : not_full[0]);
    assign accept     = InValid && InReady;
    assign push       = {accept && Select, accept && !Select};
    assign sink_ready = {ReadyB, ReadyA};
    assign pop        = valid & sink_ready;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q;
        logic [PW-1:0]    rd_ptr_q;
        logic [CW-1:0]    count_q;
        logic [CW-1:0]    count_d;

        always_comb begin
            count_d = count_q;
            case ({push[g], pop[g]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                // Clearing storage keeps the heads at zero until the first write.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                if (push[g]) begin
                    mem_q[wr_ptr_q] <= DataIn;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop[g]) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_d;
            end
        end

        assign head[g]     = mem_q[rd_ptr_q];
        assign count[g]    = count_q;
        assign valid[g]    = count_q != '0;
        assign not_full[g] = count_q != FULL;
    end

    assign DataOutA = head[0];
    assign DataOutB = head[1];
    assign ValidA   = valid[0];
    assign ValidB   = valid[1];
    assign CountA   = count[0];
    assign CountB   = count[1];

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if (!Reset && InValid) begin
            assert (!$isunknown(Select));
        end
    end
`endif

endmodule
